// File: rtl/ddr_rx_deserializer_pkg.sv
// Shared types and parameter-legality helper for the DDR receive deserializer.
package ddr_rx_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  function automatic bit rx_params_ok(input int width, input int sync_count, input int max_gap);
    return (width % 2 == 0) && (width >= 4) && (width <= 32) &&
           (sync_count >= 1) && (sync_count <= 7) &&
           (max_gap >= 2) && (max_gap <= 255);
  endfunction

endpackage

// File: rtl/ddr_rx_deserializer_align_cmp.sv
// Two-phase sync-word compare over the DDR shift register, plus window select.
// Latency: combinational.
// Backpressure: none.
module ddr_rx_align_cmp
  import ddr_rx_deserializer_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hA5)
) (
  input  logic [WIDTH:0]   sr,
  input  logic             phase,
  output logic             match0,
  output logic             match1,
  output logic [WIDTH-1:0] window
);

  logic [WIDTH-1:0] win0;
  logic [WIDTH-1:0] win1;

  assign win0   = sr[WIDTH-1:0];
  assign win1   = sr[WIDTH:1];
  assign match0 = (win0 == SYNC_WORD);
  assign match1 = (win1 == SYNC_WORD);
  assign window = phase ? win1 : win0;

endmodule

// File: rtl/ddr_rx_deserializer.sv
// Aligns the two-bit-per-clock DDR input stream to a sync word and emits WIDTH-bit words.
// Latency: word_valid 1 clk after the edge that shifts in the word's last bit.
// Backpressure: none; one word per WIDTH/2 clks while locked, enable low freezes the input.
module ddr_rx_deserializer
  import ddr_rx_deserializer_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(8'hA5),
  parameter int               SYNC_COUNT = 2,
  parameter int               MAX_GAP    = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             din_0,
  input  logic             din_1,
  output logic             io_clk_en,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  output logic             word_is_sync,
  output logic             locked,
  output logic             lock_lost
);

  localparam int HALF = WIDTH / 2;
  localparam int SW   = $clog2(HALF);
  localparam int CW   = $clog2(SYNC_COUNT + 1);
  localparam int GW   = $clog2(MAX_GAP + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LOCK  = CW'(SYNC_COUNT);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(MAX_GAP);

  if (!rx_params_ok(WIDTH, SYNC_COUNT, MAX_GAP)) begin : g_bad_params
    $error("ddr_rx_deserializer: illegal parameter set");
  end

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [WIDTH:0]   sr;
  logic             phase;
  logic [SW-1:0]    slot;
  logic [CW-1:0]    sync_cnt;
  logic [GW-1:0]    gap;
  logic             lost_pend;

  logic             match0;
  logic             match1;
  logic [WIDTH-1:0] window;
  logic             sel_match;
  logic             boundary;
  logic [CW-1:0]    cnt_inc;
  logic [GW-1:0]    gap_inc;
  logic             hunt_hit;
  logic             verify_ok;
  logic             emit;
  logic             timeout;

  ddr_rx_align_cmp #(
    .WIDTH     (WIDTH),
    .SYNC_WORD (SYNC_WORD)
  ) u_align_cmp (
    .sr     (sr),
    .phase  (phase),
    .match0 (match0),
    .match1 (match1),
    .window (window)
  );

  assign sel_match = phase ? match1 : match0;
  assign boundary  = (slot == SLOT_LAST);
  assign cnt_inc   = sync_cnt + 1'b1;
  assign gap_inc   = gap + 1'b1;
  assign locked    = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hunt_hit  = 1'b0;
    verify_ok = 1'b0;
    emit      = 1'b0;
    timeout   = 1'b0;
    if (!enable) begin
      state_nxt = ST_HUNT;
    end else begin
      case (state)
        ST_HUNT: begin
          if (match0 || match1) begin
            hunt_hit  = 1'b1;
            state_nxt = (SYNC_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (sel_match) begin
              verify_ok = 1'b1;
              if (cnt_inc == CNT_LOCK) state_nxt = ST_LOCKED;
            end else begin
              state_nxt = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            emit = 1'b1;
            // The timed-out word is still delivered; lock drops right behind it.
            if (!sel_match && (gap_inc == GAP_LIMIT)) begin
              timeout   = 1'b1;
              state_nxt = ST_HUNT;
            end
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr           <= '0;
      phase        <= 1'b0;
      slot         <= '0;
      sync_cnt     <= '0;
      gap          <= '0;
      lost_pend    <= 1'b0;
      io_clk_en    <= 1'b0;
      word_data    <= '0;
      word_valid   <= 1'b0;
      word_is_sync <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      io_clk_en    <= enable;
      word_valid   <= 1'b0;
      word_is_sync <= 1'b0;
      lost_pend    <= 1'b0;
      lock_lost    <= lost_pend & enable;
      if (enable) begin
        sr   <= {sr[WIDTH-2:0], din_0, din_1};
        slot <= boundary ? '0 : slot + 1'b1;
        if (hunt_hit) begin
          phase    <= !match0;
          slot     <= '0;
          sync_cnt <= CW'(1);
          gap      <= '0;
        end
        if (verify_ok) begin
          sync_cnt <= cnt_inc;
          gap      <= '0;
        end
        if (emit) begin
          word_data    <= window;
          word_valid   <= 1'b1;
          word_is_sync <= sel_match;
          gap          <= sel_match ? '0 : gap_inc;
          lost_pend    <= timeout;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Directed bench for ddr_rx_deserializer: table-driven stream rows plus enable/reset sequences.
module tb_ddr_rx_deserializer;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       enable = 1'b0;
  logic       din_0 = 1'b0;
  logic       din_1 = 1'b0;
  logic       io_clk_en;
  logic [7:0] word_data;
  logic       word_valid;
  logic       word_is_sync;
  logic       locked;
  logic       lock_lost;

  ddr_rx_deserializer #(
    .WIDTH      (8),
    .SYNC_WORD  (8'hA5),
    .SYNC_COUNT (2),
    .MAX_GAP    (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .din_0        (din_0),
    .din_1        (din_1),
    .io_clk_en    (io_clk_en),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_is_sync (word_is_sync),
    .locked       (locked),
    .lock_lost    (lock_lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Append-only event log, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] v_dat[$];
  logic       v_sync[$];
  int         v_cyc[$];
  int         l_cyc[$];
  logic       l_locked[$];
  int         k_cyc[$];
  logic       k_phase[$];
  logic       prev_vld = 1'b0;
  logic       prev_locked = 1'b0;
  int         b2b = 0;

  always @(negedge clk) begin
    cyc++;
    if (word_valid === 1'b1) begin
      v_dat.push_back(word_data);
      v_sync.push_back(word_is_sync);
      v_cyc.push_back(cyc);
      if (prev_vld) b2b++;
    end
    prev_vld = (word_valid === 1'b1);
    if (lock_lost === 1'b1) begin
      l_cyc.push_back(cyc);
      l_locked.push_back(locked);
    end
    if (locked === 1'b1 && !prev_locked) begin
      k_cyc.push_back(cyc);
      k_phase.push_back(dut.phase);
    end
    prev_locked = (locked === 1'b1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic b);
    din_0 = a;
    din_1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    din_0  = 1'b0;
    din_1  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    enable = 1'b1;
  endtask

  typedef struct {
    bit          pre;
    int          n_words;
    logic [47:0] wds;
    int          exp_n;
    logic [31:0] exp_wds;
    logic [3:0]  exp_sync;
    bit          exp_lock;
    bit          exp_phase;
    int          exp_lost;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{pre:1'b0, n_words:5, wds:48'hA5A53C7EA500, exp_n:3, exp_wds:32'h3C7EA500,
               exp_sync:4'b0100, exp_lock:1'b1, exp_phase:1'b0, exp_lost:0};
    tbl[1] = '{pre:1'b1, n_words:5, wds:48'hA5A53C7EA500, exp_n:3, exp_wds:32'h3C7EA500,
               exp_sync:4'b0100, exp_lock:1'b1, exp_phase:1'b1, exp_lost:0};
    tbl[2] = '{pre:1'b0, n_words:2, wds:48'hA55A00000000, exp_n:0, exp_wds:32'h0,
               exp_sync:4'b0000, exp_lock:1'b0, exp_phase:1'b0, exp_lost:0};
    tbl[3] = '{pre:1'b0, n_words:6, wds:48'hA5A511223344, exp_n:4, exp_wds:32'h11223344,
               exp_sync:4'b0000, exp_lock:1'b1, exp_phase:1'b0, exp_lost:1};

    // Reset with random input activity: every output must stay at zero.
    #1 resetn = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_0 = 1'($urandom_range(0, 1));
      din_1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("reset_outputs_c%0d", i),
            int'({io_clk_en, word_valid, word_is_sync, locked, lock_lost, word_data}), 0);
    end
    @(posedge clk);
    #1;

    for (int r = 0; r < 4; r++) begin
      vec_t v;
      bit   q[$];
      int   vb, lb, kb, nv, nl, nk;
      logic [7:0] w;
      v = tbl[r];
      do_reset();
      vb = v_cyc.size();
      lb = l_cyc.size();
      kb = k_cyc.size();
      q.delete();
      if (v.pre) q.push_back(1'b0);
      for (int i = 0; i < v.n_words; i++) begin
        w = v.wds[47-8*i -: 8];
        for (int b = 7; b >= 0; b--) q.push_back(w[b]);
      end
      if (q.size() % 2 != 0) q.push_back(1'b0);
      for (int k = 0; k < q.size(); k += 2) step(q[k], q[k+1]);
      repeat (3) step(1'b0, 1'b0);

      nv = v_cyc.size() - vb;
      nl = l_cyc.size() - lb;
      nk = k_cyc.size() - kb;
      check($sformatf("row%0d_n_valid", r), nv, v.exp_n);
      for (int i = 0; i < v.exp_n && i < nv; i++) begin
        w = v.exp_wds[31-8*i -: 8];
        check($sformatf("row%0d_word%0d_data", r, i), int'(v_dat[vb+i]), int'(w));
        check($sformatf("row%0d_word%0d_is_sync", r, i), int'(v_sync[vb+i]), int'(v.exp_sync[i]));
        if (i > 0)
          check($sformatf("row%0d_word%0d_spacing", r, i), v_cyc[vb+i] - v_cyc[vb+i-1], 4);
      end
      check($sformatf("row%0d_lock_rises", r), nk, v.exp_lock ? 1 : 0);
      if (v.exp_lock && nk > 0) begin
        check($sformatf("row%0d_phase", r), int'(k_phase[kb]), int'(v.exp_phase));
        if (v.exp_n > 0 && nv > 0)
          check($sformatf("row%0d_lock_to_first_word", r), v_cyc[vb] - k_cyc[kb], 4);
      end
      check($sformatf("row%0d_lock_lost_pulses", r), nl, v.exp_lost);
      if (v.exp_lost > 0 && nl > 0 && nv > 0) begin
        check($sformatf("row%0d_lock_lost_delay", r), l_cyc[lb] - v_cyc[v_cyc.size()-1], 1);
        check($sformatf("row%0d_locked_at_lost", r), int'(l_locked[lb]), 0);
      end
    end

    // Enable dropped two clocks into a locked word.
    begin
      int vb, lb;
      bit stream[$];
      logic [15:0] syncs;
      syncs = 16'hA5A5;
      do_reset();
      for (int b = 15; b >= 1; b -= 2) step(syncs[b], syncs[b-1]);
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      vb = v_cyc.size();
      lb = l_cyc.size();
      enable = 1'b0;
      @(negedge clk);
      check("en_locked_before_edge", int'(locked), 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("en_locked_after_edge", int'(locked), 0);
      check("en_io_clk_en_low", int'(io_clk_en), 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("en_no_word_valid", v_cyc.size() - vb, 0);
      check("en_no_lock_lost", l_cyc.size() - lb, 0);

      // Re-enable and relock from the frozen shift register.
      enable = 1'b1;
      for (int b = 15; b >= 1; b -= 2) step(syncs[b], syncs[b-1]);
      step(1'b0, 1'b0);
      @(negedge clk);
      check("reen_locked", int'(locked), 1);
      check("reen_io_clk_en", int'(io_clk_en), 1);
      check("reen_no_word_valid", v_cyc.size() - vb, 0);
      @(posedge clk);
      #1;

      // Reset pulse mid-word: outputs clear without waiting for a clock.
      vb = v_cyc.size();
      #1;
      resetn = 1'b0;
      #1;
      check("rst_mid_outputs",
            int'({io_clk_en, word_valid, word_is_sync, locked, lock_lost, word_data}), 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      check("rst_no_partial_word", v_cyc.size() - vb, 0);
      check("rst_locked_stays_low", int'(locked), 0);
    end

    check("no_back_to_back_valid", b2b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
